// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : byte-strobed data RAM, READ_LATENCY-deep read pipeline and
// an optional MMIO window (LED/HEX/cycle counter) enabled by DMEM_MMIO_EN.
// Revision 1.0
// ============================================================================
module dmem_responder #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic [9:0]  led_out,
  output logic [6:0]  hex_out,
  output logic [31:0] cycle_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  is_mmio;
  logic [31:0]           mmio_word;
  logic [31:0]           read_word;
  logic [31:0]           stage_data [READ_LATENCY];
  logic [29:0]           stage_addr [READ_LATENCY];
  logic [READ_LATENCY-1:0] stage_valid;
  logic                  unused_bits;

  assign word_idx    = addr[ADDR_WIDTH+1:2];
  assign unused_bits = &{1'b0, addr[1:0]};

`ifdef DMEM_MMIO_EN
  logic [9:0]  led_reg;
  logic [6:0]  hex_reg;
  logic [31:0] cycle_reg;

  assign is_mmio = addr[31];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_reg   <= '0;
      hex_reg   <= '0;
      cycle_reg <= '0;
    end else begin
      cycle_reg <= cycle_reg + 32'd1;
      if (we && is_mmio) begin
        // Strobes apply only to the bytes that carry implemented bits.
        if (addr[3:2] == 2'd0) begin
          if (wstrb[0]) led_reg[7:0] <= wdata[7:0];
          if (wstrb[1]) led_reg[9:8] <= wdata[9:8];
        end
        if (addr[3:2] == 2'd1 && wstrb[0]) hex_reg <= wdata[6:0];
      end
    end
  end

  always_comb begin
    mmio_word = 32'd0;
    case (addr[3:2])
      2'd0:    mmio_word = {22'd0, led_reg};
      2'd1:    mmio_word = {25'd0, hex_reg};
      2'd2:    mmio_word = cycle_reg;
      default: mmio_word = 32'd0;
    endcase
  end

  assign led_out     = led_reg;
  assign hex_out     = hex_reg;
  assign cycle_count = cycle_reg;
`else
  assign is_mmio     = 1'b0;
  assign mmio_word   = 32'd0;
  assign led_out     = '0;
  assign hex_out     = '0;
  assign cycle_count = '0;
`endif

  assign read_word = is_mmio ? mmio_word : mem[word_idx];

  always_ff @(posedge clk) begin
    if (we && !reset && !is_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Stage 1 samples after any write of the previous edge, so RAW needs no bypass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_valid <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        stage_data[i] <= '0;
        stage_addr[i] <= '0;
      end
    end else begin
      stage_valid[0] <= !we;
      stage_addr[0]  <= addr[31:2];
      stage_data[0]  <= read_word;
      for (int i = 1; i < READ_LATENCY; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_addr[i]  <= stage_addr[i-1];
        stage_data[i]  <= stage_data[i-1];
      end
    end
  end

  assign rdata       = stage_data[READ_LATENCY-1];
  assign rdata_valid = stage_valid[READ_LATENCY-1] &&
                       (stage_addr[READ_LATENCY-1] == addr[31:2]) && !we;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// tb_dmem_responder : checks latency-1 and latency-3 instances against a
// cycle-history reference model. Revision 1.0
// ============================================================================
module tb_dmem_responder;

`ifdef DMEM_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;

    logic [31:0] rdata1, rdata3, cnt1, cnt3;
    logic        valid1, valid3;
    logic [9:0]  led1, led3;
    logic [6:0]  hex1, hex3;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(10), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .wstrb(wstrb), .wdata(wdata),
        .rdata(rdata1), .rdata_valid(valid1), .led_out(led1), .hex_out(hex1),
        .cycle_count(cnt1)
    );

    dmem_responder #(.ADDR_WIDTH(10), .READ_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .wstrb(wstrb), .wdata(wdata),
        .rdata(rdata3), .rdata_valid(valid3), .led_out(led3), .hex_out(hex3),
        .cycle_count(cnt3)
    );

    typedef struct {
        logic [29:0] waddr;
        logic        wr;
        logic        rst;
        logic [31:0] data;
        logic        known;
    } hist_t;

    hist_t       hist[$];
    logic [31:0] mem_m [int];
    logic [9:0]  led_m;
    logic [6:0]  hex_m;
    logic [31:0] cnt_m;
    logic        last_valid3;
    logic [31:0] last_rdata3;
    logic [31:0] last_rdata1;

    function automatic bit to_mmio(input logic [31:0] a);
        return MMIO_EN && a[31];
    endfunction

    function automatic void model_read(input logic [31:0] a, output logic [31:0] v,
                                       output logic k);
        int idx = int'(a[11:2]);
        v = 32'd0;
        k = 1'b1;
        if (to_mmio(a)) begin
            case (a[3:2])
                2'd0:    v = {22'd0, led_m};
                2'd1:    v = {25'd0, hex_m};
                2'd2:    v = cnt_m;
                default: v = 32'd0;
            endcase
        end else if (mem_m.exists(idx)) begin
            v = mem_m[idx];
        end else begin
            k = 1'b0;
        end
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [3:0] s,
                                        input logic [31:0] d);
        int idx = int'(a[11:2]);
        logic [31:0] w;
        if (to_mmio(a)) begin
            if (a[3:2] == 2'd0) begin
                if (s[0]) led_m[7:0] = d[7:0];
                if (s[1]) led_m[9:8] = d[9:8];
            end else if (a[3:2] == 2'd1) begin
                if (s[0]) hex_m = d[6:0];
            end
        end else if (mem_m.exists(idx) || s == 4'hF) begin
            w = mem_m.exists(idx) ? mem_m[idx] : 32'd0;
            for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
            mem_m[idx] = w;
        end
    endfunction

    function automatic logic exp_valid(input int t, input int lat, input logic [31:0] a,
                                       input logic w);
        if (t < lat || w) return 1'b0;
        for (int k = t - lat; k <= t; k++) if (hist[k].rst) return 1'b0;
        if (hist[t-lat].wr) return 1'b0;
        return hist[t-lat].waddr == a[31:2];
    endfunction

    task automatic cyc(input logic [31:0] a, input logic w, input logic [3:0] s,
                       input logic [31:0] d, input logic r);
        hist_t       h;
        int          t;
        logic [31:0] v;
        logic        k, e;
        addr = a; we = w; wstrb = s; wdata = d; reset = r;
        if (r) begin cnt_m = '0; led_m = '0; hex_m = '0; end
        @(negedge clk);
        model_read(a, v, k);
        h = '{waddr: a[31:2], wr: w, rst: r, data: v, known: k};
        hist.push_back(h);
        t = hist.size() - 1;

        e = exp_valid(t, 1, a, w);
        n_assert++;
        if (valid1 !== e) begin
            n_fail++;
            $error("FAIL valid_lat1: observed %h expected %h", valid1, e);
        end
        if (e && hist[t-1].known) begin
            n_assert++;
            if (rdata1 !== hist[t-1].data) begin
                n_fail++;
                $error("FAIL rdata_lat1: observed %h expected %h", rdata1, hist[t-1].data);
            end
        end
        if (r) begin
            n_assert++;
            if (rdata1 !== 32'd0) begin
                n_fail++;
                $error("FAIL rdata_rst_lat1: observed %h expected 0", rdata1);
            end
        end

        e = exp_valid(t, 3, a, w);
        n_assert++;
        if (valid3 !== e) begin
            n_fail++;
            $error("FAIL valid_lat3: observed %h expected %h", valid3, e);
        end
        if (e && hist[t-3].known) begin
            n_assert++;
            if (rdata3 !== hist[t-3].data) begin
                n_fail++;
                $error("FAIL rdata_lat3: observed %h expected %h", rdata3, hist[t-3].data);
            end
        end
        if (r) begin
            n_assert++;
            if (rdata3 !== 32'd0) begin
                n_fail++;
                $error("FAIL rdata_rst_lat3: observed %h expected 0", rdata3);
            end
        end

        n_assert++;
        if (led1 !== led_m) begin
            n_fail++;
            $error("FAIL led_out: observed %h expected %h", led1, led_m);
        end
        n_assert++;
        if (hex3 !== hex_m) begin
            n_fail++;
            $error("FAIL hex_out: observed %h expected %h", hex3, hex_m);
        end
        n_assert++;
        if (cnt1 !== (MMIO_EN ? cnt_m : 32'd0)) begin
            n_fail++;
            $error("FAIL count_lat1: observed %h expected %h", cnt1, (MMIO_EN ? cnt_m : 32'd0));
        end
        n_assert++;
        if (cnt3 !== (MMIO_EN ? cnt_m : 32'd0)) begin
            n_fail++;
            $error("FAIL count_lat3: observed %h expected %h", cnt3, (MMIO_EN ? cnt_m : 32'd0));
        end

        last_valid3 = valid3;
        last_rdata3 = rdata3;
        last_rdata1 = rdata1;
        if (!r) begin
            if (w) model_write(a, s, d);
            cnt_m = cnt_m + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input int n);
        for (int i = 0; i < n; i++) cyc(a, 1'b0, 4'h0, 32'd0, 1'b0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        cyc(a, 1'b1, s, d, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [8:0]  pat;
        int          op, hold;

        reset = 1'b1; addr = '0; we = 1'b0; wstrb = '0; wdata = '0;
        cnt_m = '0; led_m = '0; hex_m = '0;
        @(posedge clk);
        #1;

        cyc(32'h0, 1'b0, 4'h0, 32'd0, 1'b1);
        cyc(32'h0, 1'b0, 4'h0, 32'd0, 1'b1);
        for (int i = 0; i <= 16; i++) wr(32'(i * 4), 4'hF, $urandom);

        cyc(32'h0, 1'b0, 4'h0, 32'd0, 1'b1);
        rd(32'h0, 4);
        rd(32'h4, 2);
        cyc(32'h4, 1'b0, 4'h0, 32'd0, 1'b1);
        rd(32'h4, 5);

        wr(32'h10, 4'hF, 32'h11223344);
        wr(32'h10, 4'h5, 32'hAABBCCDD);
        rd(32'h10, 4);
        n_assert++;
        if (last_rdata3 !== 32'h11BB33DD) begin
            n_fail++;
            $error("FAIL strobe_merge: observed %h expected 11bb33dd", last_rdata3);
        end
        wr(32'h10, 4'h0, 32'hFFFFFFFF);
        rd(32'h10, 4);
        n_assert++;
        if (last_rdata3 !== 32'h11BB33DD) begin
            n_fail++;
            $error("FAIL strobe_zero: observed %h expected 11bb33dd", last_rdata3);
        end

        pat = 9'b110001000;
        for (int i = 0; i < 9; i++) begin
            cyc((i < 4) ? 32'h20 : 32'h24, 1'b0, 4'h0, 32'd0, 1'b0);
            n_assert++;
            if (last_valid3 !== pat[i]) begin
                n_fail++;
                $error("FAIL lat3_pattern[%0d]: observed %h expected %h", i, last_valid3, pat[i]);
            end
        end

        wr(32'h40, 4'hF, 32'hDEADBEEF);
        rd(32'h40, 4);
        n_assert++;
        if (last_rdata3 !== 32'hDEADBEEF) begin
            n_fail++;
            $error("FAIL raw_lat3: observed %h expected deadbeef", last_rdata3);
        end
        n_assert++;
        if (last_rdata1 !== 32'hDEADBEEF) begin
            n_fail++;
            $error("FAIL raw_lat1: observed %h expected deadbeef", last_rdata1);
        end

        wr(32'h80000000, 4'hF, 32'hFFFFFFFF);
        rd(32'h80000000, 4);
        wr(32'h80000004, 4'h2, 32'h0000007F);
        rd(32'h80000004, 4);
        wr(32'h80000008, 4'hF, 32'h12345678);
        rd(32'h80000008, 4);
        rd(32'h8000000C, 4);
`ifdef DMEM_MMIO_EN
        n_assert++;
        if (led1 !== 10'h3FF) begin
            n_fail++;
            $error("FAIL led_all_ones: observed %h expected 3ff", led1);
        end
        n_assert++;
        if (hex1 !== 7'h00) begin
            n_fail++;
            $error("FAIL hex_wrong_strobe: observed %h expected 00", hex1);
        end
        n_assert++;
        if (last_rdata3 !== 32'd0) begin
            n_fail++;
            $error("FAIL reserved_reads_zero: observed %h expected 0", last_rdata3);
        end
`else
        n_assert++;
        if (led1 !== 10'h000) begin
            n_fail++;
            $error("FAIL led_tied_zero: observed %h expected 000", led1);
        end
        n_assert++;
        if (mem_m[0] !== 32'hFFFFFFFF) begin
            n_fail++;
            $error("FAIL alias_word0: observed %h expected ffffffff", mem_m[0]);
        end
`endif

        for (int n = 0; n < 60; n++) begin
            a = {1'($urandom_range(0, 1)), 19'($urandom), 10'($urandom_range(0, 16)),
                 2'($urandom)};
            op = int'($urandom_range(0, 9));
            if (op < 3) begin
                wr(a, 4'($urandom), $urandom);
            end else if (op == 9) begin
                cyc(a, 1'b0, 4'h0, 32'd0, 1'b1);
                rd(a, 3);
            end else begin
                hold = int'($urandom_range(1, 5));
                rd(a, hold);
            end
        end

`ifdef DMEM_MMIO_EN
        addr = 32'h0; we = 1'b0; reset = 1'b0;
        force dut1.cycle_reg = 32'hFFFFFFFE;
        #1;
        release dut1.cycle_reg;
        @(negedge clk);
        n_assert++;
        if (cnt1 !== 32'hFFFFFFFE) begin
            n_fail++;
            $error("FAIL wrap_pre: observed %h expected fffffffe", cnt1);
        end
        @(negedge clk);
        n_assert++;
        if (cnt1 !== 32'hFFFFFFFF) begin
            n_fail++;
            $error("FAIL wrap_max: observed %h expected ffffffff", cnt1);
        end
        @(negedge clk);
        n_assert++;
        if (cnt1 !== 32'h00000000) begin
            n_fail++;
            $error("FAIL wrap_zero: observed %h expected 0", cnt1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
